// File: rtl/h264_mbsched_pkg.sv
// Shared types and constants for the inter-path macroblock scheduler.
package h264_mbsched_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HDR    = 3'd1,
        HWAIT  = 3'd2,
        LUMA   = 3'd3,
        CHROMA = 3'd4,
        MBEND  = 3'd5,
        DRAIN  = 3'd6
    } mbsched_state_t;

    localparam int LUMA_COEFFS   = 256;
    localparam int CHROMA_COEFFS = 128;
    localparam int STALL_W       = 16;

endpackage

// File: rtl/h264_mbpos_counter.sv
// Macroblock position tracker: MBX/MBY, completed-MB count, row wrap and NEWLINE.
module h264_mbpos_counter #(
    parameter int MBW_W = 8,
    parameter int MBC_W = 16
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic             clr,
    input  logic             step,
    input  logic [MBW_W-1:0] mbwidth,
    input  logic [MBC_W-1:0] mbcount,
    output logic [MBW_W-1:0] mbx,
    output logic [MBW_W-1:0] mby,
    output logic             newline,
    output logic             last
);

    logic [MBC_W-1:0] mbdone;
    logic             row_end;

    assign row_end = (mbx == mbwidth - 1'b1);
    assign newline = step && row_end;
    // Evaluated in MBEND, before this MB is added to the done count.
    assign last    = ((mbdone + 1'b1) == mbcount);

    always_ff @(posedge CLK) begin
        if (rst || clr) begin
            mbx    <= '0;
            mby    <= '0;
            mbdone <= '0;
        end else if (step) begin
            mbdone <= mbdone + 1'b1;
            if (row_end) begin
                mbx <= '0;
                mby <= mby + 1'b1;
            end else begin
                mbx <= mbx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/h264_inter_mbsched.sv
// Inter coefficient-path MB scheduler: header trigger, luma then chroma forwarding into the buffer.
// Optional stall statistics enabled with `define H264_MBSCHED_STATS_EN.
module h264_inter_mbsched
    import h264_mbsched_pkg::*;
#(
    parameter int MBW_W = 8,
    parameter int MBC_W = 16
) (
    input  logic               CLK,
    input  logic               NEWSLICE,
    input  logic               START,
    input  logic [MBW_W-1:0]   MBWIDTH,
    input  logic [MBC_W-1:0]   MBCOUNT,
    input  logic               LVALID,
    input  logic [11:0]        LDATA,
    output logic               LREADY,
    input  logic               CVALID,
    input  logic [11:0]        CDATA,
    output logic               CREADY,
    output logic               BVALIDI,
    output logic [11:0]        BZIN,
    input  logic               BREADYI,
    input  logic               BDONE,
    output logic               NEWLINE,
    output logic               HSTART,
    input  logic               HDONE,
    output logic [MBW_W-1:0]   MBX,
    output logic [MBW_W-1:0]   MBY,
    output logic               BUSY,
    output logic               SLICEDONE,
    output logic [STALL_W-1:0] STALLCNT,
    output mbsched_state_t     STATE
);

    // Handshake: a coefficient moves on any cycle where the active source VALID and
    // BREADYI are both high; the source READY is BREADYI passed straight through.
    mbsched_state_t   state_q, state_d;
    logic [7:0]       cnt_q;
    logic [MBW_W-1:0] width_q;
    logic [MBC_W-1:0] count_q;
    logic             lxfer, cxfer, clr, step, last;

    assign lxfer = LVALID && BREADYI;
    assign cxfer = CVALID && BREADYI;
    assign BUSY  = (state_q != IDLE);
    assign STATE = state_q;

    always_comb begin
        state_d   = state_q;
        LREADY    = 1'b0;
        CREADY    = 1'b0;
        BVALIDI   = 1'b0;
        BZIN      = 12'h000;
        HSTART    = 1'b0;
        SLICEDONE = 1'b0;
        clr       = 1'b0;
        step      = 1'b0;
        case (state_q)
            IDLE: if (START) begin
                clr     = 1'b1;
                state_d = (MBCOUNT == '0) ? DRAIN : HDR;
            end
            HDR: begin
                HSTART  = 1'b1;
                state_d = HWAIT;
            end
            HWAIT: if (HDONE) state_d = LUMA;
            LUMA: begin
                BVALIDI = LVALID;
                BZIN    = LDATA;
                LREADY  = BREADYI;
                if (lxfer && cnt_q == 8'(LUMA_COEFFS - 1)) state_d = CHROMA;
            end
            CHROMA: begin
                BVALIDI = CVALID;
                BZIN    = CDATA;
                CREADY  = BREADYI;
                if (cxfer && cnt_q == 8'(CHROMA_COEFFS - 1)) state_d = MBEND;
            end
            MBEND: begin
                step    = 1'b1;
                state_d = last ? DRAIN : HDR;
            end
            DRAIN: if (BDONE) begin
                SLICEDONE = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (NEWSLICE) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            width_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            if (clr) begin
                width_q <= MBWIDTH;
                count_q <= MBCOUNT;
            end
            // Counter restarts whenever the phase ends, so chroma begins at zero.
            if ((state_q == LUMA && lxfer) || (state_q == CHROMA && cxfer))
                cnt_q <= (state_d == state_q) ? cnt_q + 8'd1 : 8'd0;
        end
    end

    h264_mbpos_counter #(.MBW_W(MBW_W), .MBC_W(MBC_W)) u_pos (
        .CLK     (CLK),
        .rst     (NEWSLICE),
        .clr     (clr),
        .step    (step),
        .mbwidth (width_q),
        .mbcount (count_q),
        .mbx     (MBX),
        .mby     (MBY),
        .newline (NEWLINE),
        .last    (last)
    );

`ifdef H264_MBSCHED_STATS_EN
    logic [STALL_W-1:0] stall_q;
    logic               stall_evt;

    assign stall_evt = ((state_q == LUMA) && LVALID && !BREADYI) ||
                       ((state_q == CHROMA) && CVALID && !BREADYI);

    always_ff @(posedge CLK) begin
        if (NEWSLICE || clr)
            stall_q <= '0;
        else if (stall_evt && stall_q != '1)
            stall_q <= stall_q + 1'b1;
    end

    assign STALLCNT = stall_q;
`else
    assign STALLCNT = '0;
`endif

endmodule
